piradip_shift_arbiter: RTL and testbench
========================================

# piradip_shift_arbiter

Round-robin arbiter that shares one AXI-Stream left shifter (piradip_left_shift, any PIPELINE setting) among N_REQ requesters. Each requester sends single-beat {shift, data} words. The arbiter issues them to the shifter through a registered slot and records the requester index in a tag FIFO. It then routes each shifter result back to the originating requester's response stream, in issue order. It sits between DSP clients and the shared shifter instance.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 32: data word width.
- SHIFT_WIDTH, $clog2(DATA_WIDTH)+1: shift-amount width, packed above data as {shift, data}.
- MAX_INFLIGHT, 8: tag FIFO depth, which is the maximum number of words issued but not yet returned. Power of 2.
- clk  in  1  single clock for the whole block.
- resetn  in  1  asynchronous, active-low reset.
- req_tdata  in  N_REQ*(SHIFT_WIDTH+DATA_WIDTH)  request words; requester i occupies slice i.
- req_tvalid  in  N_REQ  request valid, one bit per requester.
- req_tready  out  N_REQ  request ready, one bit per requester.
- rsp_tdata  out  N_REQ*DATA_WIDTH  response words; requester i occupies slice i.
- rsp_tvalid  out  N_REQ  response valid.
- rsp_tready  in  N_REQ  response ready.
- sh_in_tdata  out  SHIFT_WIDTH+DATA_WIDTH  to the shifter's data_in.
- sh_in_tvalid  out  1  to the shifter's data_in.
- sh_in_tready  in  1  from the shifter's data_in.
- sh_out_tdata  in  DATA_WIDTH  from the shifter's data_out.
- sh_out_tvalid  in  1  from the shifter's data_out.
- sh_out_tready  out  1  to the shifter's data_out.
- inflight  out  $clog2(MAX_INFLIGHT+1)  current tag FIFO occupancy.

## Operation
- **Issue slot:** a single register holding sh_in_tdata, with sh_in_tvalid as its valid.
  - The slot is free when sh_in_tvalid=0, or when sh_in_tvalid and sh_in_tready are both 1 in the same cycle.
- **Arbitration:** combinational, round-robin.
  - The search starts at (last_grant+1) mod N_REQ and picks the first i with req_tvalid[i]=1.
  - A grant is allowed only when the slot is free and inflight < MAX_INFLIGHT.
  - req_tready[i]=1 only for the granted index. At most one bit of req_tready is high.
- **On accept** (req_tvalid[i] and req_tready[i] both 1):
  - The slot loads req_tdata slice i.
  - i is pushed into the tag FIFO.
  - last_grant is set to i.
  - The tag push happens at accept, not at shifter handoff, so tags stay in issue order.
- **Return path:** combinational.
  - head = tag FIFO head.
  - rsp_tvalid[head] = sh_out_tvalid and FIFO not empty. All other rsp_tvalid bits are 0.
  - rsp_tdata is sh_out_tdata replicated into every slice; only slice head is meaningful.
  - sh_out_tready = rsp_tready[head] and FIFO not empty.
  - On a sh_out transfer, the FIFO pops.
- **Head-of-line blocking:** a stalled rsp_tready[head] stalls all returns. This is intentional, because the shifter is in-order.
- **FIFO limits:**
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - There is no push bypass when full: while inflight == MAX_INFLIGHT, no grant is issued, even if a pop occurs that cycle.
  - Pointers wrap modulo MAX_INFLIGHT.
- **Empty FIFO:** sh_out_tready=0, so a spurious shifter output stalls and is never dropped.
- **Pass-through of shift amount:** unmodified, including values ≥ DATA_WIDTH (the shifter returns 0 for these).

## Timing
- **Reset values:**
  - sh_in_tvalid=0, sh_in_tdata=0.
  - req_tready=0, rsp_tvalid=0, sh_out_tready=0.
  - inflight=0, tag FIFO empty.
  - last_grant=N_REQ-1, so requester 0 has first priority.
- **Reset mid-operation:** asserting resetn low clears all state immediately. The slot word and all outstanding tags are discarded. The shifter shares resetn.
- **Issue latency:** request accepted at edge k gives sh_in_tvalid=1 from cycle k+1.
- **Throughput:** one accept per cycle while sh_in_tready=1 and the FIFO is not full.
- **Return latency:** zero cycles from sh_out to rsp. Total latency = 1 + shifter latency.
- **Dependencies:** req_tready depends combinationally on req_tvalid, sh_in_tready and inflight. It never depends on rsp_tready.
- **Stable slot:** a held slot word (sh_in_tvalid=1, sh_in_tready=0) does not change.
- **inflight update:** changes on the clock after push or pop: +1 on push only, −1 on pop only, unchanged on both.

## Test plan
- **Single requester:** req 0 sends {s, 32'hFFFFFFFF} for s=0..32, all rsp_tready=1 → rsp 0 returns FFFFFFFF, FFFFFFFE, … 80000000, then 00000000, in order; other rsp_tvalid stay 0.
- **Round robin:** all 4 requesters continuously valid, with requester i sending data=i+1, shift=i → grant order 0,1,2,3,0,… Each requester gets exactly 25 of 100 accepts, and each rsp i returns (i+1)<<i.
- **FIFO full:** sh_out_tready blocked by holding rsp_tready[0]=0 with 10 words from req 0 offered → exactly MAX_INFLIGHT=8 accepts, inflight=8, req_tready=0. Releasing gives 8 returns, then the remaining 2 accepted.
- **Head-of-line:** req 1 issues, then req 2 issues; rsp_tready[1]=0 for 20 cycles → rsp 2 not delivered until rsp 1 completes; ordering preserved.
- **Backpressure on slot:** sh_in_tready forced 0 for 5 cycles → sh_in_tdata stable, no further req_tready, no lost or duplicated words.
- **Reset mid-stream:** resetn pulsed low with inflight=3 → all outputs at reset values. The next accept goes to requester 0 if its valid is high, and inflight restarts from 0.

Source files
------------

// File: rtl/piradip_shift_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream left shifter among N_REQ
// requesters, with a tag FIFO routing results back in issue order.
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   req_tdata/tvalid/tready      per-requester {shift, data} request streams
//   rsp_tdata/tvalid/tready      per-requester result streams
//   sh_in_tdata/tvalid/tready    issue slot towards the shared shifter
//   sh_out_tdata/tvalid/tready   results from the shared shifter
//   inflight                     words issued but not yet returned
module piradip_shift_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int SHIFT_WIDTH  = $clog2(DATA_WIDTH) + 1,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic [N_REQ*(SHIFT_WIDTH+DATA_WIDTH)-1:0]   req_tdata,
    input  logic [N_REQ-1:0]                            req_tvalid,
    output logic [N_REQ-1:0]                            req_tready,
    output logic [N_REQ*DATA_WIDTH-1:0]                 rsp_tdata,
    output logic [N_REQ-1:0]                            rsp_tvalid,
    input  logic [N_REQ-1:0]                            rsp_tready,
    output logic [SHIFT_WIDTH+DATA_WIDTH-1:0]           sh_in_tdata,
    output logic                                        sh_in_tvalid,
    input  logic                                        sh_in_tready,
    input  logic [DATA_WIDTH-1:0]                       sh_out_tdata,
    input  logic                                        sh_out_tvalid,
    output logic                                        sh_out_tready,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]           inflight
);

    localparam int WORD = SHIFT_WIDTH + DATA_WIDTH;
    localparam int IW   = $clog2(N_REQ);
    localparam int PW   = $clog2(MAX_INFLIGHT);
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] gnt;
    logic [IW-1:0] cand;
    logic [IW-1:0] head;
    logic          found;
    logic          slot_free;
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] tags [MAX_INFLIGHT];

    assign slot_free = !sh_in_tvalid || sh_in_tready;
    assign full      = (inflight == CW'(MAX_INFLIGHT));
    assign empty     = (inflight == '0);

    // Search starts one past the last winner so every requester
    // gets a turn before anyone wins twice.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % N_REQ);
            if (!found && req_tvalid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    // No grant while full, even if a pop lands this cycle, and none
    // while reset is held so req_tready reads zero during reset.
    assign accept = resetn && found && slot_free && !full;

    always_comb begin
        req_tready = '0;
        if (accept) begin
            req_tready = N_REQ'(1) << gnt;
        end
    end

    assign head          = tags[rd_ptr];
    assign sh_out_tready = !empty && rsp_tready[head];
    assign pop           = sh_out_tvalid && sh_out_tready;
    assign rsp_tdata     = {N_REQ{sh_out_tdata}};

    always_comb begin
        rsp_tvalid = '0;
        if (sh_out_tvalid && !empty) begin
            rsp_tvalid = N_REQ'(1) << head;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_in_tvalid <= 1'b0;
            sh_in_tdata  <= '0;
            last_grant   <= IW'(N_REQ - 1);
        end else if (accept) begin
            sh_in_tvalid <= 1'b1;
            sh_in_tdata  <= req_tdata[gnt*WORD +: WORD];
            last_grant   <= gnt;
        end else if (sh_in_tready) begin
            sh_in_tvalid <= 1'b0;
        end
    end

    // Tags are pushed at accept time so their order matches the
    // order words enter the in-order shifter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tags[wr_ptr] <= gnt;
        end
    end

endmodule

// File: tb/tb_piradip_shift_arbiter.sv
// Directed bench for piradip_shift_arbiter with a behavioural
// one-cycle left shifter standing in for the shared shifter.
module tb_piradip_shift_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 6;
    localparam int WW = SW + DW;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N*WW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tready;
    logic [N*DW-1:0] rsp_tdata;
    logic [N-1:0]    rsp_tvalid;
    logic [N-1:0]    rsp_tready;
    logic [WW-1:0]   sh_in_tdata;
    logic            sh_in_tvalid;
    logic            sh_in_tready;
    logic [DW-1:0]   sh_out_tdata;
    logic            sh_out_tvalid;
    logic            sh_out_tready;
    logic [3:0]      inflight;

    piradip_shift_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW),
        .SHIFT_WIDTH(SW), .MAX_INFLIGHT(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid),
        .req_tready(req_tready),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid),
        .rsp_tready(rsp_tready),
        .sh_in_tdata(sh_in_tdata), .sh_in_tvalid(sh_in_tvalid),
        .sh_in_tready(sh_in_tready),
        .sh_out_tdata(sh_out_tdata), .sh_out_tvalid(sh_out_tvalid),
        .sh_out_tready(sh_out_tready),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] shq [$];
    int acc_idx_q [$];
    int rsp_idx_q [$];
    logic [DW-1:0] rsp_data_q [$];
    int onehot_bad = 0;
    int other_rsp  = 0;
    int passed = 0;
    int total  = 0;

    function automatic logic [DW-1:0] shl(logic [WW-1:0] w);
        logic [SW-1:0] s;
        s = w[WW-1:DW];
        return (s >= SW'(DW)) ? '0 : (w[DW-1:0] << s);
    endfunction

    // Shifter model plus transfer logger.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shq.delete();
            sh_out_tvalid <= 1'b0;
            sh_out_tdata  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_tvalid[i] && req_tready[i])
                    acc_idx_q.push_back(i);
                if (rsp_tvalid[i] && rsp_tready[i]) begin
                    rsp_idx_q.push_back(i);
                    rsp_data_q.push_back(rsp_tdata[i*DW +: DW]);
                end
            end
            if ($countones(req_tready) > 1 ||
                $countones(rsp_tvalid) > 1)
                onehot_bad++;
            if (rsp_tvalid[3:1] != 3'b000)
                other_rsp++;
            if (sh_out_tvalid && sh_out_tready)
                void'(shq.pop_front());
            if (sh_in_tvalid && sh_in_tready)
                shq.push_back(shl(sh_in_tdata));
            sh_out_tvalid <= (shq.size() != 0);
            sh_out_tdata  <= (shq.size() != 0) ? shq[0] : '0;
        end
    end

    task automatic chk(string tag, logic [63:0] obs,
                       logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h",
                    tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(int i, int s, logic [DW-1:0] d);
        req_tdata[i*WW +: WW] = {SW'(s), d};
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        req_tvalid   = '0;
        req_tdata    = '0;
        rsp_tready   = '1;
        sh_in_tready = 1'b1;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    int ba, br, oth, k, bad;
    int cnt [N];
    logic [DW-1:0] e;

    initial begin
        // Reset values, with a request pending during reset.
        do_reset();
        resetn = 1'b0;
        req_tvalid = 4'b0001;
        #1;
        chk("rst_sh_in_tvalid", 64'(sh_in_tvalid), 64'd0);
        chk("rst_sh_in_tdata", 64'(sh_in_tdata), 64'd0);
        chk("rst_req_tready", 64'(req_tready), 64'd0);
        chk("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        chk("rst_sh_out_tready", 64'(sh_out_tready), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);

        // Single requester: all-ones shifted by 0..32.
        do_reset();
        ba = acc_idx_q.size();
        br = rsp_idx_q.size();
        oth = other_rsp;
        req_tvalid = 4'b0001;
        set_word(0, 0, 32'hFFFFFFFF);
        for (int c = 0; c < 400; c++) begin
            tick();
            k = acc_idx_q.size() - ba;
            if (k >= 33) req_tvalid[0] = 1'b0;
            else set_word(0, k, 32'hFFFFFFFF);
            if (rsp_idx_q.size() - br >= 33) break;
        end
        chk("t1_rsp_count", 64'(rsp_idx_q.size() - br), 64'd33);
        for (int s = 0; s < 33 && br + s < rsp_idx_q.size(); s++) begin
            e = (s == 32) ? 32'h0 : ~((32'h1 << s) - 32'h1);
            chk($sformatf("t1_rsp_s%0d", s),
                {32'(rsp_idx_q[br+s]), rsp_data_q[br+s]},
                {32'd0, e});
        end
        chk("t1_other_rsp_valid", 64'(other_rsp - oth), 64'd0);
        tick();
        chk("t1_inflight_idle", 64'(inflight), 64'd0);

        // Round robin: 100 accepts with everyone valid.
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, i, 32'(i + 1));
        ba = acc_idx_q.size();
        br = rsp_idx_q.size();
        req_tvalid = 4'b1111;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (acc_idx_q.size() - ba >= 100) req_tvalid = '0;
            if (rsp_idx_q.size() - br >= 100) break;
        end
        bad = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int j = 0; j < 100 && ba + j < acc_idx_q.size(); j++) begin
            if (acc_idx_q[ba+j] != j % 4) bad++;
            cnt[acc_idx_q[ba+j]]++;
        end
        chk("t2_accept_total", 64'(acc_idx_q.size() - ba), 64'd100);
        chk("t2_grant_order_errors", 64'(bad), 64'd0);
        chk("t2_share_req0", 64'(cnt[0]), 64'd25);
        chk("t2_share_req1", 64'(cnt[1]), 64'd25);
        chk("t2_share_req2", 64'(cnt[2]), 64'd25);
        chk("t2_share_req3", 64'(cnt[3]), 64'd25);
        bad = 0;
        for (int j = br; j < rsp_idx_q.size(); j++) begin
            unique case (rsp_idx_q[j])
                0: if (rsp_data_q[j] != 32'd1)  bad++;
                1: if (rsp_data_q[j] != 32'd4)  bad++;
                2: if (rsp_data_q[j] != 32'd12) bad++;
                default: if (rsp_data_q[j] != 32'd32) bad++;
            endcase
        end
        chk("t2_rsp_total", 64'(rsp_idx_q.size() - br), 64'd100);
        chk("t2_rsp_value_errors", 64'(bad), 64'd0);

        // FIFO full: response 0 blocked, 10 words offered.
        do_reset();
        rsp_tready = 4'b1110;
        ba = acc_idx_q.size();
        br = rsp_idx_q.size();
        req_tvalid = 4'b0001;
        set_word(0, 1, 32'd0);
        for (int c = 0; c < 30; c++) begin
            tick();
            k = acc_idx_q.size() - ba;
            if (k >= 10) req_tvalid[0] = 1'b0;
            else set_word(0, 1, 32'(k));
        end
        chk("t3_accepts_when_full", 64'(acc_idx_q.size() - ba), 64'd8);
        chk("t3_inflight_full", 64'(inflight), 64'd8);
        chk("t3_req_tready_full", 64'(req_tready), 64'd0);
        chk("t3_no_rsp_blocked", 64'(rsp_idx_q.size() - br), 64'd0);
        rsp_tready = 4'b1111;
        for (int c = 0; c < 200; c++) begin
            tick();
            k = acc_idx_q.size() - ba;
            if (k >= 10) req_tvalid[0] = 1'b0;
            else set_word(0, 1, 32'(k));
            if (rsp_idx_q.size() - br >= 10) break;
        end
        chk("t3_accepts_total", 64'(acc_idx_q.size() - ba), 64'd10);
        chk("t3_rsp_total", 64'(rsp_idx_q.size() - br), 64'd10);
        bad = 0;
        for (int j = 0; j < 10 && br + j < rsp_idx_q.size(); j++)
            if (rsp_idx_q[br+j] != 0 ||
                rsp_data_q[br+j] != 32'(2 * j)) bad++;
        chk("t3_rsp_order_errors", 64'(bad), 64'd0);
        tick();
        chk("t3_inflight_drained", 64'(inflight), 64'd0);

        // Head-of-line: req1 then req2, response 1 stalled.
        do_reset();
        rsp_tready = 4'b1101;
        ba = acc_idx_q.size();
        br = rsp_idx_q.size();
        set_word(1, 1, 32'd5);
        set_word(2, 2, 32'd3);
        req_tvalid = 4'b0010;
        for (int c = 0; c < 20 && acc_idx_q.size() - ba < 1; c++) tick();
        req_tvalid = 4'b0100;
        for (int c = 0; c < 20 && acc_idx_q.size() - ba < 2; c++) tick();
        req_tvalid = 4'b0000;
        for (int c = 0; c < 20; c++) tick();
        chk("t4_no_rsp_while_stalled", 64'(rsp_idx_q.size() - br), 64'd0);
        chk("t4_rsp_tvalid_head", 64'(rsp_tvalid), 64'b0010);
        chk("t4_sh_out_tready_stalled", 64'(sh_out_tready), 64'd0);
        chk("t4_inflight", 64'(inflight), 64'd2);
        rsp_tready = 4'b1111;
        for (int c = 0; c < 20 && rsp_idx_q.size() - br < 2; c++) tick();
        chk("t4_rsp_total", 64'(rsp_idx_q.size() - br), 64'd2);
        if (rsp_idx_q.size() - br >= 2) begin
            chk("t4_first_rsp", {32'(rsp_idx_q[br]), rsp_data_q[br]},
                {32'd1, 32'd10});
            chk("t4_second_rsp",
                {32'(rsp_idx_q[br+1]), rsp_data_q[br+1]},
                {32'd2, 32'd12});
        end

        // Slot backpressure.
        do_reset();
        sh_in_tready = 1'b0;
        ba = acc_idx_q.size();
        br = rsp_idx_q.size();
        set_word(0, 0, 32'd7);
        set_word(1, 3, 32'd9);
        req_tvalid = 4'b0011;
        for (int c = 0; c < 20 && acc_idx_q.size() - ba < 1; c++) tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t5_slot_stable_c%0d", c),
                64'(sh_in_tdata), 64'({6'd0, 32'd7}));
            chk($sformatf("t5_no_grant_c%0d", c),
                64'(req_tready), 64'd0);
        end
        chk("t5_one_accept_held", 64'(acc_idx_q.size() - ba), 64'd1);
        sh_in_tready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (acc_idx_q.size() - ba >= 4) req_tvalid = '0;
            if (rsp_idx_q.size() - br >= 4) break;
            tick();
        end
        chk("t5_accepts", 64'(acc_idx_q.size() - ba), 64'd4);
        chk("t5_rsp_total", 64'(rsp_idx_q.size() - br), 64'd4);
        bad = 0;
        for (int j = 0; j < 4 && br + j < rsp_idx_q.size(); j++)
            if (rsp_idx_q[br+j] != j % 2 ||
                rsp_data_q[br+j] != ((j % 2) ? 32'd72 : 32'd7)) bad++;
        chk("t5_rsp_order_errors", 64'(bad), 64'd0);

        // Reset mid-stream with three words outstanding.
        do_reset();
        rsp_tready = 4'b0000;
        ba = acc_idx_q.size();
        set_word(0, 0, 32'd1);
        req_tvalid = 4'b0001;
        for (int c = 0; c < 30 && acc_idx_q.size() - ba < 3; c++) tick();
        req_tvalid = 4'b0000;
        tick();
        tick();
        chk("t6_inflight_before", 64'(inflight), 64'd3);
        @(negedge clk);
        resetn = 1'b0;
        req_tvalid = 4'b0101;
        set_word(0, 0, 32'h55);
        set_word(2, 0, 32'h66);
        #1;
        chk("t6_sh_in_tvalid", 64'(sh_in_tvalid), 64'd0);
        chk("t6_sh_in_tdata", 64'(sh_in_tdata), 64'd0);
        chk("t6_req_tready", 64'(req_tready), 64'd0);
        chk("t6_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        chk("t6_sh_out_tready", 64'(sh_out_tready), 64'd0);
        chk("t6_inflight_cleared", 64'(inflight), 64'd0);
        tick();
        resetn = 1'b1;
        rsp_tready = 4'b1111;
        ba = acc_idx_q.size();
        br = rsp_idx_q.size();
        #1;
        chk("t6_grant_req0_first", 64'(req_tready), 64'b0001);
        tick();
        req_tvalid = 4'b0000;
        chk("t6_inflight_restart", 64'(inflight), 64'd1);
        if (acc_idx_q.size() > ba)
            chk("t6_first_accept_idx", 64'(acc_idx_q[ba]), 64'd0);
        else
            chk("t6_first_accept_seen", 64'd0, 64'd1);
        for (int c = 0; c < 20 && rsp_idx_q.size() - br < 1; c++) tick();
        tick();
        chk("t6_rsp_total", 64'(rsp_idx_q.size() - br), 64'd1);
        if (rsp_idx_q.size() > br)
            chk("t6_rsp_value", {32'(rsp_idx_q[br]), rsp_data_q[br]},
                {32'd0, 32'h55});

        chk("onehot_violations", 64'(onehot_bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
